// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian word from four byte reads.
// Optional 16-entry direct-mapped instruction cache when ICACHE_EN is defined.
module if_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        jmp,
    input  logic        stall_i,
    output logic        pc_stall_o,
    output logic        mem_re_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_busy_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o
);

    typedef enum logic {ST_ISSUE, ST_VALID} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_k, w_k_nxt;
    logic        r_pend, w_pend_nxt;
    logic [1:0]  r_lane, w_lane_nxt;
    logic [23:0] r_buf, w_buf_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [31:0] r_inst_pc, w_inst_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        w_hit;
    logic [31:0] w_hit_data;
    logic        w_fill;

`ifdef ICACHE_EN
    logic [15:0] r_cv;
    logic [25:0] r_ctag  [16];
    logic [31:0] r_cdata [16];
    logic [3:0]  w_idx;

    assign w_idx      = pc_i[5:2];
    // A lookup is only meaningful at the very start of a fetch.
    assign w_hit      = (r_state == ST_ISSUE) && (r_k == 3'd0) && !r_pend &&
                        r_cv[w_idx] && (r_ctag[w_idx] == pc_i[31:6]);
    assign w_hit_data = r_cdata[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cv <= '0;
        end else if (w_fill) begin
            r_cv[w_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays have no reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_ctag[w_idx]  <= pc_i[31:6];
            r_cdata[w_idx] <= {mem_data_i, r_buf};
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ISSUE;
            r_k       <= 3'd0;
            r_pend    <= 1'b0;
            r_lane    <= 2'd0;
            r_buf     <= '0;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_pend    <= w_pend_nxt;
            r_lane    <= w_lane_nxt;
            r_buf     <= w_buf_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_pend_nxt    = 1'b0;
        w_lane_nxt    = r_lane;
        w_buf_nxt     = r_buf;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_valid_nxt   = r_valid;
        w_fill        = 1'b0;
        pc_stall_o    = 1'b1;
        mem_re_o      = 1'b0;
        mem_addr_o    = pc_i + {29'd0, r_k};

        case (r_state)
            ST_ISSUE: begin
                if (w_hit) begin
                    w_inst_nxt    = w_hit_data;
                    w_inst_pc_nxt = pc_i;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = ST_VALID;
                end else begin
                    mem_re_o = (r_k <= 3'd3);
                    if (mem_re_o && !mem_busy_i) begin
                        w_k_nxt    = r_k + 3'd1;
                        w_pend_nxt = 1'b1;
                        w_lane_nxt = r_k[1:0];
                    end
                end
                // The byte for the request accepted last edge arrives now.
                if (r_pend) begin
                    case (r_lane)
                        2'd0: w_buf_nxt[7:0]   = mem_data_i;
                        2'd1: w_buf_nxt[15:8]  = mem_data_i;
                        2'd2: w_buf_nxt[23:16] = mem_data_i;
                        default: begin
                            w_inst_nxt    = {mem_data_i, r_buf};
                            w_inst_pc_nxt = pc_i;
                            w_valid_nxt   = 1'b1;
                            w_state_nxt   = ST_VALID;
                            w_k_nxt       = 3'd0;
                            w_fill        = 1'b1;
                        end
                    endcase
                end
            end
            ST_VALID: begin
                pc_stall_o = stall_i;
                if (!stall_i) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_ISSUE;
                    w_k_nxt     = 3'd0;
                end
            end
            default: w_state_nxt = ST_ISSUE;
        endcase

        // A redirect wins over everything, including a byte still in flight.
        if (jmp) begin
            w_state_nxt = ST_ISSUE;
            w_k_nxt     = 3'd0;
            w_pend_nxt  = 1'b0;
            w_buf_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_fill      = 1'b0;
        end
    end

    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: PC register and byte memory models, a vector table,
// a scoreboard of expected {pc, word}, and hand sequences for reset, jump and cache cases.
`timescale 1ns/1ps
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_reg;
    logic [31:0] pc_i;
    logic [31:0] jmp_target = '0;
    logic        jmp = 1'b0;
    logic        stall_i = 1'b0;
    logic        mem_busy_i = 1'b0;
    logic [7:0]  mem_data_i;
    logic        pc_stall_o, mem_re_o, inst_valid_o;
    logic [31:0] mem_addr_o, inst_o, inst_pc_o;

    logic [7:0]  mem [512];
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] pc;
        int          busy_byte;
        int          busy_len;
        int          stall_len;
        int          exp_lat;
    } vec_t;

    if_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .jmp          (jmp),
        .stall_i      (stall_i),
        .pc_stall_o   (pc_stall_o),
        .mem_re_o     (mem_re_o),
        .mem_addr_o   (mem_addr_o),
        .mem_busy_i   (mem_busy_i),
        .mem_data_i   (mem_data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    // PC register: loads the jump target, or advances by 4 when not held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pc_reg <= '0;
        else if (jmp)         pc_reg <= jmp_target;
        else if (!pc_stall_o) pc_reg <= pc_reg + 32'd4;
    end
    assign pc_i = pc_reg;

    // Byte memory: data appears the cycle after an accepted request.
    always @(posedge clk) begin
        if (mem_re_o && !mem_busy_i) mem_data_i <= mem[mem_addr_o[8:0]];
        else                         mem_data_i <= 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [31:0] a;
        exp_word = '0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
            exp_word[8*k +: 8] = mem[a[8:0]];
        end
    endfunction

    task automatic jump_to(input logic [31:0] pc);
        jmp        = 1'b1;
        jmp_target = pc;
        @(posedge clk);
        @(negedge clk);
        jmp = 1'b0;
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        exp_t e;
        jump_to(pc);
        e.pc   = pc;
        e.word = exp_word(pc);
        sb.push_back(e);
    endtask

    // Waits (bounded) for inst_valid_o, optionally stalling memory on one byte.
    task automatic wait_valid(input logic [31:0] pc, input int busy_byte, input int busy_len,
                              output int lat);
        int   left;
        logic was_busy;
        left     = busy_len;
        was_busy = 1'b0;
        lat      = 0;
        while (!inst_valid_o && lat < 40) begin
            if (was_busy) check("busy_hold_addr", mem_addr_o, pc + 32'(busy_byte));
            mem_busy_i = (left > 0) && mem_re_o && (mem_addr_o == pc + 32'(busy_byte));
            was_busy   = mem_busy_i;
            if (mem_busy_i) left--;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        mem_busy_i = 1'b0;
        check("valid_seen", {31'd0, inst_valid_o}, 32'd1);
    endtask

    task automatic sb_compare();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: got valid inst_pc %h expected no output", inst_pc_o);
        end else begin
            e = sb.pop_front();
            check("inst_pc", inst_pc_o, e.pc);
            check("inst_word", inst_o, e.word);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [31:0] held;
        start_fetch(v.pc);
        wait_valid(v.pc, v.busy_byte, v.busy_len, lat);
        check("latency", 32'(lat), 32'(v.exp_lat));
        sb_compare();
        held    = inst_o;
        stall_i = (v.stall_len > 0);
        for (int c = 0; c < v.stall_len; c++) begin
            #1 check("stall_pc_hold", {31'd0, pc_stall_o}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            check("stall_inst_held", inst_o, held);
            check("stall_valid_held", {31'd0, inst_valid_o}, 32'd1);
        end
        stall_i = 1'b0;
        #1 check("release_pc_adv", {31'd0, pc_stall_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("next_addr", mem_addr_o, v.pc + 32'd4);
        check("next_re", {31'd0, mem_re_o}, 32'd1);
        check("next_valid_low", {31'd0, inst_valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] seq_pc[8];
        logic        seq_hit[8];
        int          lat;
        exp_t        e;
        int          guard;

        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

        vecs[0] = '{32'h0000_0020, 2, 3, 4, 8};
        vecs[1] = '{32'h0000_01C0, -1, 0, 0, 5};
        vecs[2] = '{32'hFFFF_FFFE, -1, 0, 1, 5};
        vecs[3] = '{32'h0000_0084, 0, 2, 0, 7};
        vecs[4] = '{32'h0000_0048, 3, 1, 2, 6};

        // Reset state, then the first fetch from address 0.
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_inst_pc", inst_pc_o, 32'd0);
        rst_n = 1'b1;
        e.pc = 32'd0; e.word = 32'h0000_0013;
        sb.push_back(e);
        for (int c = 0; c < 4; c++) begin
            #1 check("first_addr", mem_addr_o, 32'(c));
            check("first_re", {31'd0, mem_re_o}, 32'd1);
            check("first_not_valid", {31'd0, inst_valid_o}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("first_valid_cycle5", {31'd0, inst_valid_o}, 32'd1);
        sb_compare();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Redirect after byte 2 is accepted; the in-flight byte 3 must be dropped.
        jump_to(32'h0000_0060);
        guard = 0;
        while (!(mem_re_o && mem_addr_o == 32'h62) && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("jmp_reach_byte2", 32'(guard < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start_fetch(32'h0000_0100);
        check("jmp_valid_cleared", {31'd0, inst_valid_o}, 32'd0);
        wait_valid(32'h100, -1, 0, lat);
        check("jmp_latency", 32'(lat), 32'd5);
        sb_compare();

        // Same index, different tag, then a repeated pair that should hit with a cache.
        seq_pc = '{32'h0, 32'h40, 32'h0, 32'h40, 32'h0, 32'h4, 32'h0, 32'h4};
        seq_hit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            logic hit;
`ifdef ICACHE_EN
            hit = seq_hit[i];
`else
            hit = 1'b0;
`endif
            start_fetch(seq_pc[i]);
            check("cache_re", {31'd0, mem_re_o}, {31'd0, !hit});
            wait_valid(seq_pc[i], -1, 0, lat);
            check("cache_latency", 32'(lat), hit ? 32'd1 : 32'd5);
            sb_compare();
        end

        // Asynchronous reset in the middle of a fetch.
        jump_to(32'h0000_0040);
        guard = 0;
        while (!(mem_re_o && mem_addr_o == 32'h42) && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("rst_reach_byte2", 32'(guard < 20), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("midrst_inst", inst_o, 32'd0);
        check("midrst_inst_pc", inst_pc_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e.pc = 32'd0; e.word = 32'h0000_0013;
        sb.push_back(e);
        #1 check("rst_restart_addr", mem_addr_o, 32'd0);
        check("rst_restart_re", {31'd0, mem_re_o}, 32'd1);
        @(negedge clk);
        lat = 0;
        while (!inst_valid_o && lat < 40) begin
            lat++;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_restart_latency", 32'(lat + 1), 32'd5);
        sb_compare();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
